// File: rtl/scan_mux_pkg.sv
// Shared encodings for the scan multiplexer: mode decode and sweep FSM states.
package scan_mux_pkg;

   typedef enum logic [1:0] {
      ModeDirect = 2'b00,
      ModeScan   = 2'b01,
      ModeHold   = 2'b10,
      ModeSweep  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

endpackage

// File: rtl/mux_n.sv
// Combinational N:1 channel selector; o_hit flags a select that names a real channel.
module mux_n #(
   parameter int unsigned WIDTH    = 1,
   parameter int unsigned CHANNELS = 8,
   localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
   input  logic [CHANNELS*WIDTH-1:0] i_data,
   input  logic [SEL_W-1:0]          i_sel,
   output logic [WIDTH-1:0]          o_data,
   output logic                      o_hit
);

   // Out-of-range selects fall through to zero data with o_hit low.
   always_comb begin
      o_data = '0;
      o_hit  = 1'b0;
      for (int unsigned n = 0; n < CHANNELS; n++) begin
         if (i_sel == SEL_W'(n)) begin
            o_data = i_data[n*WIDTH +: WIDTH];
            o_hit  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/scan_mux.sv
// Registered channel multiplexer with direct, free-running scan, hold and one-shot sweep modes.
module scan_mux #(
   parameter int unsigned WIDTH    = 1,
   parameter int unsigned CHANNELS = 8,
   localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      CP,
   input  logic                      MR,
   input  logic                      _E,
   input  logic [1:0]                MODE,
   input  logic [SEL_W-1:0]          S,
   input  logic [CHANNELS*WIDTH-1:0] I,
   input  logic                      START,
   output logic [WIDTH-1:0]          Y,
   output logic [WIDTH-1:0]          _Y,
   output logic [SEL_W-1:0]          CH,
   output logic                      VALID,
   output logic                      DONE
);
   import scan_mux_pkg::*;

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

   state_e           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_y, r_y_n, w_y_nxt;
   logic [SEL_W-1:0] r_ch, w_ch_nxt;
   logic [SEL_W-1:0] r_cnt, w_cnt_nxt;
   logic [SEL_W-1:0] r_idx, w_idx_nxt;
   logic             r_valid, w_valid_nxt;
   logic             r_done, w_done_nxt;
   logic [SEL_W-1:0] w_sel;
   logic [WIDTH-1:0] w_mux_data;
   logic             w_hit;
   mode_e            w_mode;

   assign w_mode = mode_e'(MODE);

   always_comb begin
      case (w_mode)
         ModeDirect: w_sel = S;
         ModeScan:   w_sel = r_cnt;
         default:    w_sel = r_idx;
      endcase
   end

   mux_n #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS)
   ) u_mux (
      .i_data (I),
      .i_sel  (w_sel),
      .o_data (w_mux_data),
      .o_hit  (w_hit)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_y_nxt     = r_y;
      w_ch_nxt    = r_ch;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_valid_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      if (_E) begin
         // Disabled: blank the output but keep counters and sweep position intact.
         w_y_nxt = '0;
      end else begin
         case (w_mode)
            ModeDirect: begin
               w_state_nxt = StIdle;
               w_y_nxt     = w_mux_data;
               w_ch_nxt    = S;
               w_valid_nxt = w_hit;
            end
            ModeScan: begin
               w_state_nxt = StIdle;
               w_y_nxt     = w_mux_data;
               w_ch_nxt    = r_cnt;
               w_valid_nxt = 1'b1;
               w_cnt_nxt   = (r_cnt == LAST_CH) ? '0 : r_cnt + 1'b1;
            end
            ModeHold: begin
               w_state_nxt = StIdle;
            end
            default: begin
               unique case (r_state)
                  StIdle: begin
                     if (START) begin
                        w_state_nxt = StRun;
                        w_idx_nxt   = '0;
                     end
                  end
                  StRun: begin
                     w_y_nxt     = w_mux_data;
                     w_ch_nxt    = r_idx;
                     w_valid_nxt = 1'b1;
                     if (r_idx == LAST_CH) begin
                        w_state_nxt = StDone;
                        w_done_nxt  = 1'b1;
                        w_idx_nxt   = '0;
                     end else begin
                        w_idx_nxt = r_idx + 1'b1;
                     end
                  end
                  StDone: begin
                     w_state_nxt = StIdle;
                  end
                  default: begin
                     w_state_nxt = StIdle;
                  end
               endcase
            end
         endcase
      end
   end

   always_ff @(posedge CP or posedge MR) begin
      if (MR) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge CP or posedge MR) begin
      if (MR) begin
         r_y     <= '0;
         r_y_n   <= '1;
         r_ch    <= '0;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_y     <= w_y_nxt;
         r_y_n   <= ~w_y_nxt;
         r_ch    <= w_ch_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_valid <= w_valid_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign Y     = r_y;
   assign _Y    = r_y_n;
   assign CH    = r_ch;
   assign VALID = r_valid;
   assign DONE  = r_done;

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: three instances (8, 5 and 6 channels, 8-bit data).
module tb_scan_mux;

   localparam logic [1:0] M_DIRECT = 2'b00;
   localparam logic [1:0] M_SCAN   = 2'b01;
   localparam logic [1:0] M_HOLD   = 2'b10;
   localparam logic [1:0] M_SWEEP  = 2'b11;

   logic        cp = 1'b0;
   logic        mr, en_n, start;
   logic [1:0]  mode8, mode5, mode6;
   logic [2:0]  s8, s5, s6;
   logic [63:0] i8;
   logic [39:0] i5;
   logic [47:0] i6;
   logic [7:0]  y8, yn8, y5, yn5, y6, yn6;
   logic [2:0]  ch8, ch5, ch6;
   logic        valid8, valid5, valid6, done8, done5, done6;

   typedef struct {
      logic [7:0] y;
      logic [2:0] ch;
      logic       chk_ch;
      logic       valid;
      logic       done;
   } exp_t;

   exp_t       q8[$];
   exp_t       q5[$];
   exp_t       q6[$];
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] last_y8  = 8'h00;
   logic [2:0] last_ch8 = 3'd0;

   always #5 cp = ~cp;

   scan_mux #(.WIDTH(8), .CHANNELS(8)) u_dut8 (
      .CP(cp), .MR(mr), ._E(en_n), .MODE(mode8), .S(s8), .I(i8), .START(start),
      .Y(y8), ._Y(yn8), .CH(ch8), .VALID(valid8), .DONE(done8)
   );

   scan_mux #(.WIDTH(8), .CHANNELS(5)) u_dut5 (
      .CP(cp), .MR(mr), ._E(en_n), .MODE(mode5), .S(s5), .I(i5), .START(start),
      .Y(y5), ._Y(yn5), .CH(ch5), .VALID(valid5), .DONE(done5)
   );

   scan_mux #(.WIDTH(8), .CHANNELS(6)) u_dut6 (
      .CP(cp), .MR(mr), ._E(en_n), .MODE(mode6), .S(s6), .I(i6), .START(start),
      .Y(y6), ._Y(yn6), .CH(ch6), .VALID(valid6), .DONE(done6)
   );

   function automatic logic [7:0] chan8(int n);
      return (n == 3) ? 8'hA5 : 8'(32'h20 + n);
   endfunction

   function automatic void push8(logic [7:0] y, logic [2:0] ch, logic chk, logic v, logic d);
      q8.push_back('{y: y, ch: ch, chk_ch: chk, valid: v, done: d});
      last_y8 = y;
      if (chk) last_ch8 = ch;
   endfunction

   task automatic test_reset;
      mr = 1'b1; en_n = 1'b0; start = 1'b0;
      mode8 = M_HOLD; mode5 = M_HOLD; mode6 = M_HOLD;
      s8 = 3'd0; s5 = 3'd0; s6 = 3'd0;
      #2;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (y8 !== 8'h00 || yn8 !== 8'hFF || ch8 !== 3'd0 || valid8 !== 1'b0 || done8 !== 1'b0) begin
            failures++;
            $display("FAIL reset8 step %0d: Y=%h _Y=%h CH=%0d VALID=%b DONE=%b, required 00 ff 0 0 0",
                     k, y8, yn8, ch8, valid8, done8);
         end
         checks++;
         if (y5 !== 8'h00 || yn5 !== 8'hFF || ch5 !== 3'd0 || valid5 !== 1'b0 || done5 !== 1'b0) begin
            failures++;
            $display("FAIL reset5 step %0d: Y=%h _Y=%h CH=%0d VALID=%b DONE=%b, required 00 ff 0 0 0",
                     k, y5, yn5, ch5, valid5, done5);
         end
         @(posedge cp); #1;
      end
      @(negedge cp);
      mr = 1'b0;
   endtask

   task automatic test_scan;
      exp_t e;
      for (int k = 0; k < 10; k++) begin
         @(negedge cp);
         en_n  = (k == 7);
         mode5 = (k == 6) ? M_HOLD : M_SCAN;
         if (k < 6)       q5.push_back('{y: 8'(10 + k % 5), ch: 3'(k % 5), chk_ch: 1, valid: 1, done: 0});
         else if (k == 6) q5.push_back('{y: 8'd10, ch: 3'd0, chk_ch: 1, valid: 0, done: 0});
         else if (k == 7) q5.push_back('{y: 8'd0, ch: 3'd0, chk_ch: 0, valid: 0, done: 0});
         else             q5.push_back('{y: 8'(3 + k), ch: 3'(k - 7), chk_ch: 1, valid: 1, done: 0});
         @(posedge cp); #1;
         e = q5.pop_front();
         checks++;
         if (y5 !== e.y || yn5 !== ~e.y || valid5 !== e.valid || done5 !== e.done ||
             (e.chk_ch && ch5 !== e.ch)) begin
            failures++;
            $display("FAIL scan step %0d: Y=%0d _Y=%h CH=%0d VALID=%b DONE=%b, required Y=%0d CH=%0d VALID=%b",
                     k, y5, yn5, ch5, valid5, done5, e.y, e.ch, e.valid);
         end
      end
      @(negedge cp);
      en_n = 1'b0; mode5 = M_HOLD;
   endtask

   task automatic test_out_of_range;
      int   sels[5] = '{7, 5, 6, 2, 0};
      exp_t e;
      for (int k = 0; k < 5; k++) begin
         @(negedge cp);
         mode6 = M_DIRECT;
         s6    = 3'(sels[k]);
         if (sels[k] < 6) q6.push_back('{y: 8'(32'h60 + sels[k]), ch: 3'(sels[k]), chk_ch: 1, valid: 1, done: 0});
         else             q6.push_back('{y: 8'h00, ch: 3'(sels[k]), chk_ch: 1, valid: 0, done: 0});
         @(posedge cp); #1;
         e = q6.pop_front();
         checks++;
         if (y6 !== e.y || yn6 !== ~e.y || ch6 !== e.ch || valid6 !== e.valid || done6 !== e.done) begin
            failures++;
            $display("FAIL out_of_range S=%0d: Y=%h CH=%0d VALID=%b DONE=%b, required Y=%h CH=%0d VALID=%b",
                     sels[k], y6, ch6, valid6, done6, e.y, e.ch, e.valid);
         end
      end
      @(negedge cp);
      mode6 = M_HOLD;
   endtask

   task automatic test_direct;
      int   sels[4] = '{3, 0, 7, 3};
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         @(negedge cp);
         mode8 = M_DIRECT;
         s8    = 3'(sels[k]);
         push8(chan8(sels[k]), 3'(sels[k]), 1'b1, 1'b1, 1'b0);
         @(posedge cp); #1;
         e = q8.pop_front();
         checks++;
         if (y8 !== e.y || yn8 !== ~e.y || ch8 !== e.ch || valid8 !== e.valid || done8 !== e.done) begin
            failures++;
            $display("FAIL direct S=%0d: Y=%h _Y=%h CH=%0d VALID=%b DONE=%b, required Y=%h _Y=%h CH=%0d VALID=1",
                     sels[k], y8, yn8, ch8, valid8, done8, e.y, ~e.y, e.ch);
         end
      end
   endtask

   // Second START pulses land in RUN (k=3) and DONE (k=9); both must be ignored.
   task automatic test_sweep;
      exp_t e;
      for (int k = 0; k < 11; k++) begin
         @(negedge cp);
         mode8 = M_SWEEP;
         start = (k == 0 || k == 3 || k == 9);
         if (k >= 1 && k <= 8) push8(chan8(k - 1), 3'(k - 1), 1'b1, 1'b1, k == 8);
         else                  push8(last_y8, last_ch8, 1'b1, 1'b0, 1'b0);
         @(posedge cp); #1;
         e = q8.pop_front();
         checks++;
         if (y8 !== e.y || yn8 !== ~e.y || valid8 !== e.valid || done8 !== e.done ||
             ch8 !== e.ch) begin
            failures++;
            $display("FAIL sweep step %0d: Y=%h CH=%0d VALID=%b DONE=%b, required Y=%h CH=%0d VALID=%b DONE=%b",
                     k, y8, ch8, valid8, done8, e.y, e.ch, e.valid, e.done);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_enable;
      exp_t e;
      int   nxt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge cp);
         mode8 = M_SWEEP;
         start = (k == 0);
         en_n  = (k == 3 || k == 4);
         if (k == 0 || k == 11) begin
            push8(last_y8, last_ch8, 1'b1, 1'b0, 1'b0);
         end else if (en_n) begin
            push8(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
         end else begin
            push8(chan8(nxt), 3'(nxt), 1'b1, 1'b1, nxt == 7);
            nxt++;
         end
         @(posedge cp); #1;
         e = q8.pop_front();
         checks++;
         if (y8 !== e.y || yn8 !== ~e.y || valid8 !== e.valid || done8 !== e.done ||
             (e.chk_ch && ch8 !== e.ch)) begin
            failures++;
            $display("FAIL enable step %0d: Y=%h _Y=%h CH=%0d VALID=%b DONE=%b, required Y=%h CH=%0d VALID=%b DONE=%b",
                     k, y8, yn8, ch8, valid8, done8, e.y, e.ch, e.valid, e.done);
         end
      end
      start = 1'b0; en_n = 1'b0;
   endtask

   // Dropping to HOLD mid-sweep must return the FSM to idle: no further samples, no DONE.
   task automatic test_leave_sweep;
      exp_t e;
      for (int k = 0; k < 6; k++) begin
         @(negedge cp);
         mode8 = (k == 3) ? M_HOLD : M_SWEEP;
         start = (k == 0);
         if (k == 1 || k == 2) push8(chan8(k - 1), 3'(k - 1), 1'b1, 1'b1, 1'b0);
         else                  push8(last_y8, last_ch8, 1'b1, 1'b0, 1'b0);
         @(posedge cp); #1;
         e = q8.pop_front();
         checks++;
         if (y8 !== e.y || valid8 !== e.valid || done8 !== e.done || ch8 !== e.ch) begin
            failures++;
            $display("FAIL leave_sweep step %0d: Y=%h CH=%0d VALID=%b DONE=%b, required Y=%h CH=%0d VALID=%b DONE=%b",
                     k, y8, ch8, valid8, done8, e.y, e.ch, e.valid, e.done);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid_sweep;
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         @(negedge cp);
         mode8 = M_SWEEP;
         start = (k == 0);
         @(posedge cp); #1;
      end
      start = 1'b0;
      #2;
      mr = 1'b1;
      #1;
      checks++;
      if (y8 !== 8'h00 || yn8 !== 8'hFF || ch8 !== 3'd0 || valid8 !== 1'b0 || done8 !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: Y=%h _Y=%h CH=%0d VALID=%b DONE=%b, required 00 ff 0 0 0",
                  y8, yn8, ch8, valid8, done8);
      end
      for (int k = 0; k < 2; k++) begin
         @(posedge cp); #1;
         checks++;
         if (done8 !== 1'b0 || valid8 !== 1'b0 || y8 !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold step %0d: Y=%h VALID=%b DONE=%b, required 00 0 0",
                     k, y8, valid8, done8);
         end
      end
      last_y8 = 8'h00; last_ch8 = 3'd0;
      for (int k = 0; k < 2; k++) begin
         @(negedge cp);
         mr = 1'b0;
         mode8 = (k == 0) ? M_DIRECT : M_SWEEP;
         s8 = 3'd3;
         if (k == 0) push8(8'hA5, 3'd3, 1'b1, 1'b1, 1'b0);
         else        push8(last_y8, last_ch8, 1'b1, 1'b0, 1'b0);
         @(posedge cp); #1;
         e = q8.pop_front();
         checks++;
         if (y8 !== e.y || yn8 !== ~e.y || ch8 !== e.ch || valid8 !== e.valid || done8 !== e.done) begin
            failures++;
            $display("FAIL post_reset step %0d: Y=%h CH=%0d VALID=%b DONE=%b, required Y=%h CH=%0d VALID=%b",
                     k, y8, ch8, valid8, done8, e.y, e.ch, e.valid);
         end
      end
   endtask

   initial begin
      for (int n = 0; n < 8; n++) i8[n*8 +: 8] = chan8(n);
      for (int n = 0; n < 5; n++) i5[n*8 +: 8] = 8'(10 + n);
      for (int n = 0; n < 6; n++) i6[n*8 +: 8] = 8'(32'h60 + n);
      test_reset();
      test_scan();
      test_out_of_range();
      test_direct();
      test_sweep();
      test_enable();
      test_leave_sweep();
      test_reset_mid_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
               checks, failures);
      $fatal(1);
   end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1: bit width of each data channel.
REQ-002 The block SHALL have parameter CHANNELS, default 8: number of input channels, legal range 2..256.
REQ-003 The block SHALL have derived localparam SEL_W = $clog2(CHANNELS): width of the channel select.
REQ-004 Port CP, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port MR, input, 1: asynchronous, active-high master reset.
REQ-006 Port _E, input, 1: active-low enable.
REQ-007 Port MODE, input, 2: 00 DIRECT, 01 SCAN, 10 HOLD, 11 SWEEP.
REQ-008 Port S, input, SEL_W: channel select used in DIRECT mode.
REQ-009 Port I, input, CHANNELS*WIDTH: packed inputs; channel n occupies I[n*WIDTH +: WIDTH].
REQ-010 Port START, input, 1: single-cycle pulse that launches a SWEEP.
REQ-011 Port Y, output, WIDTH: registered selected data.
REQ-012 Port _Y, output, WIDTH: bitwise complement of Y, registered in the same cycle as Y.
REQ-013 Port CH, output, SEL_W: channel index that produced the current Y.
REQ-014 Port VALID, output, 1: Y/CH hold a fresh sample captured on the last edge.
REQ-015 Port DONE, output, 1: one-cycle pulse on the final sample of a SWEEP.

Function
REQ-016 Y, _Y, CH and VALID SHALL update only on a rising CP edge, giving one-cycle latency from I/S to Y.
REQ-017 While _E=1 on an edge, the block SHALL load Y=0, _Y=all-ones and VALID=0, freeze the scan counter, and leave the FSM state unchanged.
REQ-018 In DIRECT mode with _E=0, each edge SHALL load Y=I[S], CH=S and VALID=1.
REQ-019 In SCAN mode with _E=0, each edge SHALL load Y=I[cnt] and CH=cnt, then step cnt to cnt+1, wrapping from CHANNELS-1 to 0; VALID=1.
REQ-020 In HOLD mode, Y, CH and cnt SHALL retain their values and VALID SHALL be 0.
REQ-021 In SWEEP mode, a 3-state FSM SHALL run: IDLE -> RUN on START=1 with _E=0; RUN samples channels 0..CHANNELS-1 on consecutive edges; RUN -> DONE after channel CHANNELS-1; DONE -> IDLE on the next edge.
REQ-022 DONE SHALL be 1 for exactly the one cycle in which Y holds channel CHANNELS-1 of a sweep.
REQ-023 In SWEEP mode, VALID SHALL be 1 only in RUN cycles; Y SHALL hold its value in IDLE.
REQ-024 A START while in RUN or DONE SHALL be ignored.
REQ-025 Deasserting _E during RUN SHALL pause the sweep; the sweep SHALL resume at the same channel when _E returns to 0.
REQ-026 Leaving SWEEP mode mid-sweep SHALL force the FSM to IDLE on the next edge without a DONE pulse.
REQ-027 When CHANNELS is not a power of two and S>=CHANNELS in DIRECT mode, the block SHALL load Y=0, CH=S and VALID=0.
REQ-028 Entering SCAN mode SHALL continue from the current cnt; it SHALL NOT restart at 0.

Reset
REQ-029 While MR=1, the block SHALL immediately force Y=0, _Y=all-ones, CH=0, VALID=0, DONE=0, cnt=0 and FSM=IDLE, independent of CP.
REQ-030 MR asserted mid-sweep SHALL abort the sweep with no DONE pulse.
REQ-031 The first edge after MR falls SHALL behave as a normal edge for the current MODE.

Structure
REQ-032 The MODE encodings and the FSM state enum (IDLE, RUN, DONE) SHALL live in a shared package, scan_mux_pkg.
REQ-033 The combinational N:1 selector SHALL be a sub-module, mux_n (parameters WIDTH, CHANNELS), with the registers, counter and FSM in scan_mux.

Verification
REQ-034 Reset test: MR=1 mid-operation -> Y=0, _Y=1, CH=0, VALID=0 immediately; no DONE pulse.
REQ-035 DIRECT test: WIDTH=8, CHANNELS=8, _E=0, S=3, channel 3 data=0xA5 -> after 1 edge Y=0xA5, _Y=0x5A, CH=3, VALID=1.
REQ-036 SCAN test: CHANNELS=5, inputs 10..14 -> Y=10,11,12,13,14,10 on successive edges; CH wraps 4->0.
REQ-037 SWEEP test: START pulse -> exactly 8 VALID cycles on CH 0..7; DONE high only with CH=7; a second START during RUN is ignored.
REQ-038 Enable test: _E=1 on the edge when CH=2 during a sweep -> Y=0, _Y=all-ones, VALID=0; after _E=0 the sweep resumes at CH=2.
REQ-039 Out-of-range test: CHANNELS=6, S=7 -> Y=0, VALID=0.
